// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec4_16 scan controller and its loop-back checker.
package dec_scan_pkg;

  localparam int ADDR_W = 4;
  localparam int LINES  = 16;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE,
    DONE
  } state_e;

  // Pattern a healthy decoder produces: one-hot on addr when enabled, else all zeros.
  function automatic logic [LINES-1:0] exp_onehot(input logic [ADDR_W-1:0] addr,
                                                  input logic en);
    logic [LINES-1:0] v;
    v = '0;
    if (en) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_scan_check.sv
// Combinational comparison of the looped-back decoder output against the expected pattern.
module dec_scan_check
  import dec_scan_pkg::*;
(
  input  logic [ADDR_W-1:0] a_i,
  input  logic              enn_i,
  input  logic [LINES-1:0]  d_i,
  output logic              mismatch_o
);

  assign mismatch_o = (d_i != exp_onehot(a_i, enn_i));

endmodule

// File: rtl/dec4_16_scan_ctrl.sv
// Scan controller driving a dec4_16 decoder through all addresses with programmable
// dwell, checking its looped-back output and keeping sticky error status.
module dec4_16_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int DWELL_W  = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                cont,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [ADDR_W-1:0]   a,
  output logic                enn,
  input  logic [LINES-1:0]    d,
  output logic                busy,
  output logic                done,
  output logic                wrap,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_blank,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINES - 1);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    a_q, a_d;
  logic                 enn_q, enn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
  logic                 err_blank_q, err_blank_d;
  logic [ERRCNT_W-1:0]  err_count_q, err_count_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 cont_q, cont_d;
  logic                 mismatch;

  dec_scan_check u_check (
    .a_i        (a_q),
    .enn_i      (enn_q),
    .d_i        (d),
    .mismatch_o (mismatch)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    cont_d      = cont_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_blank_d = err_blank_q;
    err_count_d = err_count_q;
    wrap_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = BLANK;
          dwell_d     = dwell;
          cont_d      = cont;
          a_d         = '0;
          err_d       = 1'b0;
          err_addr_d  = '0;
          err_blank_d = 1'b0;
          err_count_d = '0;
        end
      end
      BLANK: begin
        if (mismatch) begin
          err_d       = 1'b1;
          err_blank_d = 1'b1;
          err_count_d = sat_inc(err_count_q);
          if (!err_q) err_addr_d = '0;
        end
        cnt_d   = dwell_q;
        state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          if (mismatch) begin
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
            if (!err_q) err_addr_d = a_q;
          end
          if (a_q != LAST_ADDR) begin
            a_d   = a_q + ADDR_W'(1);
            cnt_d = dwell_q;
          end else if (cont_q) begin
            a_d     = '0;
            wrap_d  = 1'b1;
            cnt_d   = dwell_q;
            state_d = BLANK;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort keeps the address and any error captured this cycle, but suppresses pulses.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      a_d     = a_q;
      wrap_d  = 1'b0;
    end

    enn_d  = (state_d == DRIVE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      enn_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_blank_q <= 1'b0;
      err_count_q <= '0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      enn_q       <= enn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_blank_q <= err_blank_d;
      err_count_q <= err_count_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      cont_q      <= cont_d;
    end
  end

  assign a         = a_q;
  assign enn       = enn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign err_blank = err_blank_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dec4_16_scan_ctrl.sv
// Bench for dec4_16_scan_ctrl: a configurable faulty decoder model, a vector table,
// hand-written multi-cycle sequences and randomized faults against an arithmetic model.
module tb_dec4_16_scan_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, start, stop, cont;
  logic [7:0]       dwell;
  logic [3:0]       a;
  logic             enn;
  logic [15:0]      d;
  logic             busy, done, wrap, err, err_blank;
  logic [3:0]       err_addr;
  logic [CNT_W-1:0] err_count;

  int               fault_kind;
  int               fault_bit;
  logic [15:0]      bad_mask;
  logic [15:0]      corrupt;
  logic             blank_bad;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec4_16_scan_ctrl #(.DWELL_W(8), .ERRCNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .dwell(dwell),
    .a(a), .enn(enn), .d(d), .busy(busy), .done(done), .wrap(wrap), .err(err),
    .err_addr(err_addr), .err_blank(err_blank), .err_count(err_count)
  );

  // Decoder model: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 d=1 while disabled, 4 random corruption.
  always_comb begin
    d = enn ? (16'h0001 << a) : 16'h0000;
    case (fault_kind)
      1: d[fault_bit] = 1'b0;
      2: d[fault_bit] = 1'b1;
      3: if (!enn) d = 16'h0001;
      4: begin
        if (enn && bad_mask[a]) d = d ^ corrupt;
        if (!enn && blank_bad) d = 16'h8000;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a"}, 32'(a), 0);
    check({tag, "_enn"}, 32'(enn), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wrap"}, 32'(wrap), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_err_addr"}, 32'(err_addr), 0);
    check({tag, "_err_blank"}, 32'(err_blank), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  // One single pass from a start pulse; per-cycle outputs follow from the pass arithmetic.
  task automatic run_pass(input int dw, input int e_err, input int e_addr,
                          input int e_blank, input int e_cnt, input string tag);
    int dev;
    int last;
    int drive_end;
    int ea, eenn, ebusy, edone;
    dev       = 0;
    drive_end = 17 + 16 * dw;
    last      = drive_end + 2;
    dwell     = 8'(dw);
    cont      = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= last; j++) begin
      ebusy = (j <= drive_end + 1) ? 1 : 0;
      edone = (j == drive_end + 1) ? 1 : 0;
      eenn  = (j >= 2 && j <= drive_end) ? 1 : 0;
      if (j == 1)              ea = 0;
      else if (j <= drive_end) ea = (j - 2) / (dw + 1);
      else                     ea = 15;
      if (a !== 4'(ea) || enn !== 1'(eenn) || busy !== 1'(ebusy) ||
          done !== 1'(edone) || wrap !== 1'b0)
        dev++;
      if (j < last) tick();
    end
    check({tag, "_seq"}, 32'(dev), 0);
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_err_addr"}, 32'(err_addr), 32'(e_addr));
    check({tag, "_err_blank"}, 32'(err_blank), 32'(e_blank));
    check({tag, "_err_count"}, 32'(err_count), 32'(e_cnt));
  endtask

  typedef struct {
    int    dw;
    int    kind;
    int    fbit;
    int    e_err;
    int    e_addr;
    int    e_blank;
    int    e_cnt;
    string name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dev, wraps, dn, e_cnt, e_addr, e_blank, dw;
    int ea, eenn, ewrap, pos;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, "good_dw0"};
    vecs[1] = '{3, 0, 0, 0, 0, 0, 0, "good_dw3"};
    vecs[2] = '{0, 1, 5, 1, 5, 0, 1, "stuck0_b5"};
    vecs[3] = '{1, 3, 0, 1, 0, 1, 1, "blank_fault"};
    vecs[4] = '{2, 1, 0, 1, 0, 0, 1, "stuck0_b0"};
    vecs[5] = '{0, 2, 12, 1, 0, 1, CNT_MAX, "stuck1_b12_sat"};
    vecs[6] = '{0, 1, 15, 1, 15, 0, 1, "stuck0_b15"};

    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; dwell = '0;
    fault_kind = 0; fault_bit = 0; bad_mask = '0; corrupt = '0; blank_bad = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst_hold");
    rst = 1'b0;
    tick();
    check_reset_vals("rst_rel");

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 0);
    tick();
    check("ss_busy2", 32'(busy), 0);
    check("ss_enn", 32'(enn), 0);

    for (int i = 0; i < 7; i++) begin
      fault_kind = vecs[i].kind;
      fault_bit  = vecs[i].fbit;
      run_pass(vecs[i].dw, vecs[i].e_err, vecs[i].e_addr, vecs[i].e_blank,
               vecs[i].e_cnt, vecs[i].name);
      tick();
    end

    // stop on the very cycle a mismatch is sampled
    fault_kind = 1; fault_bit = 5; dwell = 8'd0; cont = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("stopmis_a", 32'(a), 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopmis_busy", 32'(busy), 0);
    check("stopmis_enn", 32'(enn), 0);
    check("stopmis_err", 32'(err), 1);
    check("stopmis_err_addr", 32'(err_addr), 5);
    check("stopmis_err_count", 32'(err_count), 1);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0) dn++;
      tick();
    end
    check("stopmis_nodone", 32'(dn), 0);

    // continuous mode: wrap every 17 cycles, busy-start and config changes ignored, stop at a=9
    fault_kind = 0; dwell = 8'd0; cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dev = 0; wraps = 0;
    for (int j = 1; j <= 62; j++) begin
      pos   = (j - 1) % 17;
      eenn  = (pos != 0) ? 1 : 0;
      ea    = (pos == 0) ? 0 : pos - 1;
      ewrap = (j >= 18 && ((j - 18) % 17) == 0) ? 1 : 0;
      if (a !== 4'(ea) || enn !== 1'(eenn) || busy !== 1'b1 ||
          done !== 1'b0 || wrap !== 1'(ewrap))
        dev++;
      if (wrap === 1'b1) wraps++;
      if (j == 5) begin start = 1'b1; dwell = 8'd7; cont = 1'b0; end
      if (j == 6) start = 1'b0;
      if (j == 62) begin
        check("cont_a9", 32'(a), 9);
        stop = 1'b1;
      end
      tick();
    end
    stop = 1'b0;
    check("cont_seq", 32'(dev), 0);
    check("cont_wraps", 32'(wraps), 3);
    check("cont_stop_busy", 32'(busy), 0);
    check("cont_stop_enn", 32'(enn), 0);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) dn++;
      tick();
    end
    check("cont_stop_idle", 32'(dn), 0);

    // reset in the middle of a scan at a=7, after an error has been logged
    fault_kind = 1; fault_bit = 5; dwell = 8'd0; cont = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("midrst_pre_a", 32'(a), 7);
    check("midrst_pre_err", 32'(err), 1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    tick();
    check("midrst_idle_busy", 32'(busy), 0);

    // randomized faults against the counting model
    for (int r = 0; r < 8; r++) begin
      dw         = int'($urandom_range(0, 4));
      fault_kind = 4;
      bad_mask   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      corrupt    = 16'($urandom_range(1, 65535));
      blank_bad  = 1'($urandom_range(0, 1));
      e_blank    = blank_bad ? 1 : 0;
      e_cnt      = e_blank + $countones(bad_mask);
      e_addr     = 0;
      if (!blank_bad) begin
        for (int k = 15; k >= 0; k--) if (bad_mask[k]) e_addr = k;
      end
      run_pass(dw, (e_cnt > 0) ? 1 : 0, e_addr, e_blank,
               (e_cnt > CNT_MAX) ? CNT_MAX : e_cnt, $sformatf("rand%0d", r));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
